usr_serdes_ctrl: RTL and testbench

Controller that sequences a parameterized universal shift register core to perform one full-duplex serial word transfer.
- Accepts a parallel word over a valid/ready handshake and loads it.
- Shifts it out serially, MSB-first or LSB-first, while shifting the serial input into the vacated end.
- Returns the captured word over a second valid/ready handshake.
- Sits between a parallel producer/consumer and a bit-serial link.

---
 rtl/usr_serdes_pkg.sv | 10 +
 rtl/usr_serdes_ctrl_if.sv | 12 +
 rtl/univ_shift_core.sv | 24 ++
 rtl/usr_serdes_ctrl.sv | 77 +++++++
 tb/tb_usr_serdes_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/usr_serdes_pkg.sv
// usr_serdes_pkg: shared state encoding, core select codes and shift directions
package usr_serdes_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR = 2'b01;
  localparam logic [1:0] SEL_SHL = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/usr_serdes_ctrl_if.sv
// usr_serdes_ctrl_if: parallel word in/out handshakes between producer/consumer and controller
interface usr_serdes_ctrl_if #(parameter int WIDTH = 4);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic in_dir;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  modport master(output in_valid, in_data, in_dir, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, in_dir, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/univ_shift_core.sv
// univ_shift_core: universal register with hold, shift right, shift left and parallel load
module univ_shift_core
  import usr_serdes_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel_i,
  input  logic             l_fill_i,
  input  logic             r_fill_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;
  // l_fill enters at the MSB on a right shift, r_fill at the LSB on a left shift
  always_comb q_d = sel_i == SEL_LOAD ? d_i :
                    sel_i == SEL_SHR ? {l_fill_i, q_q[WIDTH-1:1]} :
                    sel_i == SEL_SHL ? {q_q[WIDTH-2:0], r_fill_i} : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/usr_serdes_ctrl.sv
// usr_serdes_ctrl: sequences univ_shift_core through one full-duplex serial word transfer
module usr_serdes_ctrl
  import usr_serdes_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  usr_serdes_ctrl_if.slave   bus,
  input  logic               shift_en_i,
  input  logic               abort_i,
  input  logic               ser_in_i,
  output logic               ser_out_o,
  output logic               ser_out_valid_o,
  output logic               busy_o,
  output logic [1:0]         sel_o
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d;
  logic busy_q, out_valid_q;
  logic accept, shift, last;
  logic [WIDTH-1:0] reg_q;
  univ_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .sel_i    (sel_o),
    .l_fill_i (ser_in_i),
    .r_fill_i (ser_in_i),
    .d_i      (bus.in_data),
    .q_o      (reg_q)
  );
  // abort outranks every other input, including an offered word in IDLE
  always_comb begin
    bus.in_ready = !rst && state_q == IDLE && !abort_i;
    accept = bus.in_ready && bus.in_valid;
    shift = state_q == SHIFT && shift_en_i && !abort_i;
    last = cnt_q == CNT_W'(WIDTH - 1);
    sel_o = accept ? SEL_LOAD : shift ? (dir_q == DIR_RIGHT ? SEL_SHR : SEL_SHL) : SEL_HOLD;
    ser_out_o = dir_q == DIR_RIGHT ? reg_q[0] : reg_q[WIDTH-1];
    ser_out_valid_o = shift;
    state_d = state_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (abort_i) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (accept) begin
      state_d = SHIFT;
      cnt_d = '0;
      dir_d = bus.in_dir;
    end else if (shift) begin
      state_d = last ? DONE : SHIFT;
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dir_q <= DIR_LEFT;
      busy_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      busy_q <= state_d != IDLE;
      out_valid_q <= state_d == DONE;
    end
  assign busy_o = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = reg_q;
endmodule

// File: tb/tb_usr_serdes_ctrl.sv
// tb_usr_serdes_ctrl: directed transfers; serial bits and returned words checked by a scoreboard monitor
module tb_usr_serdes_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic shift_en = 1'b0;
  logic abort = 1'b0;
  logic ser_in = 1'b0;
  logic ser_out, ser_out_valid, busy;
  logic [1:0] sel;
  logic [3:0] mdl;
  int pass_n = 0;
  int total_n = 0;
  logic bit_q[$];
  logic [3:0] word_q[$];
  usr_serdes_ctrl_if #(.WIDTH(4)) bus();
  usr_serdes_ctrl #(.WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .shift_en_i      (shift_en),
    .abort_i         (abort),
    .ser_in_i        (ser_in),
    .ser_out_o       (ser_out),
    .ser_out_valid_o (ser_out_valid),
    .busy_o          (busy),
    .sel_o           (sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (ser_out_valid) begin
      if (bit_q.size() == 0) chk("ser_out_unexpected", 1, 0);
      else chk("ser_out", 32'(ser_out), 32'(bit_q.pop_front()));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (word_q.size() == 0) chk("out_word_unexpected", 1, 0);
      else chk("out_data", 32'(bus.out_data), 32'(word_q.pop_front()));
    end
  end
  task automatic expect_bits(input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) bit_q.push_back(b[3-k]);
  endtask
  task automatic accept(input logic [3:0] d, input logic dir);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_dir = dir;
    #1;
    chk("accept_in_ready", 32'(bus.in_ready), 1);
    chk("accept_sel", 32'(sel), 3);
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    mdl = d;
  endtask
  task automatic run_shifts(input logic [6:0] en, input int n, input logic [3:0] sin, input logic dir);
    int j = 0;
    for (int k = 0; k < n; k++) begin
      shift_en = en[n-1-k];
      ser_in = shift_en ? sin[3-j] : 1'b0;
      #1;
      chk("shift_sel", 32'(sel), shift_en ? (dir ? 1 : 2) : 0);
      chk("shift_reg", 32'(bus.out_data), 32'(mdl));
      chk("shift_sov", 32'(ser_out_valid), 32'(shift_en));
      if (shift_en) begin
        mdl = dir ? {ser_in, mdl[3:1]} : {mdl[2:0], ser_in};
        j++;
      end
      @(posedge clk) #1;
    end
    shift_en = 1'b0;
  endtask
  task automatic deliver();
    bus.out_ready = 1'b1;
    #1;
    chk("done_out_valid", 32'(bus.out_valid), 1);
    chk("done_sel", 32'(sel), 0);
    @(posedge clk) #1;
    bus.out_ready = 1'b0;
    chk("after_done_busy", 32'(busy), 0);
    chk("after_done_out_valid", 32'(bus.out_valid), 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_dir = 1'b0;
    bus.out_ready = 1'b0;
    mdl = '0;
    @(posedge clk) #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_reg", 32'(bus.out_data), 0);
    chk("rst_sov", 32'(ser_out_valid), 0);
    chk("rst_sel", 32'(sel), 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk) #1;
    // MSB-first 1011 with serial input 0,1,1,0
    expect_bits(4'b1011, 4);
    word_q.push_back(4'b0110);
    accept(4'b1011, 1'b0);
    chk("shift_busy", 32'(busy), 1);
    run_shifts(7'b0001111, 4, 4'b0110, 1'b0);
    deliver();
    // LSB-first, same stimulus
    expect_bits(4'b1101, 4);
    word_q.push_back(4'b0110);
    accept(4'b1011, 1'b1);
    run_shifts(7'b0001111, 4, 4'b0110, 1'b1);
    deliver();
    // gapped shift_en 1,0,0,1,1,0,1
    expect_bits(4'b1100, 4);
    word_q.push_back(4'b1010);
    accept(4'b1100, 1'b0);
    run_shifts(7'b1001101, 7, 4'b1010, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = 4'b0011;
    bus.in_dir = 1'b0;
    repeat (3) begin
      #1;
      chk("hold_out_valid", 32'(bus.out_valid), 1);
      chk("hold_out_data", 32'(bus.out_data), 32'h a);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk) #1;
    end
    deliver();
    expect_bits(4'b0011, 4);
    word_q.push_back(4'b0000);
    accept(4'b0011, 1'b0);
    run_shifts(7'b0001111, 4, 4'b0000, 1'b0);
    deliver();
    // abort after two shifts, with shift_en also raised
    expect_bits(4'b1000, 2);
    accept(4'b1011, 1'b0);
    run_shifts(7'b0000011, 2, 4'b0100, 1'b0);
    abort = 1'b1;
    shift_en = 1'b1;
    #1;
    chk("abort_sel", 32'(sel), 0);
    chk("abort_sov", 32'(ser_out_valid), 0);
    @(posedge clk) #1;
    abort = 1'b0;
    shift_en = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cnt", 32'(dut.cnt_q), 0);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_reg_held", 32'(bus.out_data), 32'(mdl));
    // abort in IDLE blocks an offered word
    bus.in_valid = 1'b1;
    bus.in_data = 4'b0101;
    abort = 1'b1;
    #1;
    chk("idle_abort_in_ready", 32'(bus.in_ready), 0);
    chk("idle_abort_sel", 32'(sel), 0);
    @(posedge clk) #1;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    expect_bits(4'b1010, 4);
    word_q.push_back(4'b1111);
    accept(4'b0101, 1'b1);
    run_shifts(7'b0001111, 4, 4'b1111, 1'b1);
    deliver();
    // asynchronous reset mid-shift
    expect_bits(4'b0100, 2);
    accept(4'b0111, 1'b0);
    run_shifts(7'b0000011, 2, 4'b1100, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_reg", 32'(bus.out_data), 0);
    chk("arst_state", 32'(dut.state_q), 0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(posedge clk) #1;
    chk("bits_drained", bit_q.size(), 0);
    chk("words_drained", word_q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
